// File: rtl/pulse_stretcher_if.sv
// Signal bundle between a strobe source and the pulse stretcher.
// The source drives strobes and the overflow clear; the stretcher returns level, busy and overflow.
interface pulse_stretcher_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] pulse_in;
  logic             clear_overflow;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] overflow;

  modport master (
    output pulse_in, clear_overflow,
    input  level_out, busy, overflow
  );

  modport slave (
    input  pulse_in, clear_overflow,
    output level_out, busy, overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Per-channel strobe-to-level stretcher: HIGH_CYCLES high, then at least LOW_CYCLES low,
// with a saturating pending counter so back-to-back strobes are replayed rather than merged.
module pulse_stretcher #(
  parameter int WIDTH       = 2,
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_BITS   = 3
) (
  input  logic            clk,
  input  logic            async_nreset,
  pulse_stretcher_if.slave bus
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0]        HIGH_RELOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]        LOW_RELOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0]        CNT_ONE     = CW'(1);
  localparam logic [PEND_BITS-1:0] PEND_ONE    = PEND_BITS'(1);
  localparam logic [PEND_BITS-1:0] PEND_MAX    = {PEND_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  logic [WIDTH-1:0] level_vec;
  logic [WIDTH-1:0] busy_vec;
  logic [WIDTH-1:0] ovf_vec;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      state_t               state_reg, state_next;
      logic [CW-1:0]        cnt_reg, cnt_next;
      logic [PEND_BITS-1:0] pend_reg, pend_next;
      logic                 ovf_reg, ovf_next;
      logic                 level_reg;
      logic                 inc, dec, ovf_set;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        inc        = 1'b0;
        dec        = 1'b0;
        ovf_set    = 1'b0;

        unique case (state_reg)
          IDLE: begin
            if (bus.pulse_in[gi]) begin
              state_next = HIGH;
              cnt_next   = HIGH_RELOAD;
            end
          end
          HIGH: begin
            inc = bus.pulse_in[gi];
            if (cnt_reg == '0) begin
              state_next = GAP;
              cnt_next   = LOW_RELOAD;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          GAP: begin
            inc = bus.pulse_in[gi];
            if (cnt_reg == '0) begin
              if ((pend_reg != '0) || bus.pulse_in[gi]) begin
                state_next = HIGH;
                cnt_next   = HIGH_RELOAD;
                // With nothing queued, a strobe landing here is the restart itself.
                if (pend_reg != '0) dec = 1'b1;
                else                inc = 1'b0;
              end else begin
                state_next = IDLE;
              end
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          default: state_next = IDLE;
        endcase

        if (inc && !dec) begin
          if (pend_reg == PEND_MAX) ovf_set = 1'b1;
          else                      pend_next = pend_reg + PEND_ONE;
        end else if (dec && !inc) begin
          pend_next = pend_reg - PEND_ONE;
        end

        ovf_next = ovf_set | (ovf_reg & ~bus.clear_overflow);
      end

      always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          pend_reg  <= '0;
          ovf_reg   <= 1'b0;
          level_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pend_reg  <= pend_next;
          ovf_reg   <= ovf_next;
          level_reg <= (state_next == HIGH);
        end
      end

      assign level_vec[gi] = level_reg;
      assign busy_vec[gi]  = (state_reg != IDLE) | (pend_reg != '0);
      assign ovf_vec[gi]   = ovf_reg;
    end
  endgenerate

  assign bus.level_out = level_vec;
  assign bus.busy      = busy_vec;
  assign bus.overflow  = ovf_vec;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: each strobe pushes its expected high window into a per-channel queue;
// a negedge monitor pops and checks every window that appears on level_out.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic async_nreset = 1'b0;
  always #5 clk = ~clk;

  pulse_stretcher_if #(.WIDTH(2)) bus ();

  pulse_stretcher #(
    .WIDTH(2), .HIGH_CYCLES(4), .LOW_CYCLES(4), .PEND_BITS(3)
  ) dut (
    .clk(clk),
    .async_nreset(async_nreset),
    .bus(bus.slave)
  );

  typedef struct {
    int start;
    int len;
  } win_t;

  win_t q0[$];
  win_t q1[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    while ((cyc - t0) < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test(input string name);
    bus.pulse_in = 2'b00;
    bus.clear_overflow = 1'b0;
    async_nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    async_nreset = 1'b1;
    t0 = cyc;
    $display("-- %s", name);
  endtask

  task automatic end_test(input string name);
    chk({name, "_q0_left"}, q0.size(), 0);
    chk({name, "_q1_left"}, q1.size(), 0);
  endtask

  // Monitor: one line per observed window, checked against the queued expectation.
  bit   in_hi[2];
  int   hi_len[2];
  bit   have_exp[2];
  win_t cur_exp[2];

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (bus.level_out[ch] === 1'b1) begin
        if (!in_hi[ch]) begin
          in_hi[ch] = 1'b1;
          hi_len[ch] = 1;
          have_exp[ch] = 1'b0;
          if (ch == 0 && q0.size() > 0) begin
            cur_exp[ch] = q0.pop_front();
            have_exp[ch] = 1'b1;
          end else if (ch == 1 && q1.size() > 0) begin
            cur_exp[ch] = q1.pop_front();
            have_exp[ch] = 1'b1;
          end
          if (have_exp[ch]) begin
            chk($sformatf("ch%0d_start", ch), cyc - t0, cur_exp[ch].start);
          end else begin
            total++;
            bad++;
            $display("FAIL unexpected_window ch%0d: got start at cycle %0d required no window", ch, cyc - t0);
          end
        end else begin
          hi_len[ch]++;
        end
      end else if (in_hi[ch]) begin
        in_hi[ch] = 1'b0;
        $display("window ch%0d start=%0d len=%0d", ch, cyc - t0 - hi_len[ch], hi_len[ch]);
        if (have_exp[ch])
          chk($sformatf("ch%0d_len", ch), hi_len[ch], cur_exp[ch].len);
      end
    end
  end

  initial begin
    bus.pulse_in = 2'b00;
    bus.clear_overflow = 1'b0;

    // 1: single strobe
    start_test("single strobe");
    chk("rst_level", bus.level_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.overflow, 0);
    q0.push_back('{11, 4});
    wait_cyc(10); bus.pulse_in = 2'b01;
    chk("t1_busy_c10", bus.busy, 2'b00);
    wait_cyc(11); bus.pulse_in = 2'b00;
    chk("t1_busy_c11", bus.busy, 2'b01);
    wait_cyc(18); chk("t1_busy_c18", bus.busy, 2'b01);
    chk("t1_level_c18", bus.level_out, 2'b00);
    wait_cyc(19); chk("t1_busy_c19", bus.busy, 2'b00);
    wait_cyc(30); end_test("t1");

    // 2: back-to-back strobes
    start_test("two strobes");
    q0.push_back('{11, 4});
    q0.push_back('{19, 4});
    wait_cyc(10); bus.pulse_in = 2'b01;
    wait_cyc(12); bus.pulse_in = 2'b00;
    wait_cyc(26); chk("t2_busy_c26", bus.busy, 2'b01);
    wait_cyc(27); chk("t2_busy_c27", bus.busy, 2'b00);
    wait_cyc(35); end_test("t2");

    // 3: held strobe saturates pending
    start_test("held strobe overflow");
    for (int k = 0; k < 9; k++) q0.push_back('{11 + 8 * k, 4});
    wait_cyc(10); bus.pulse_in = 2'b01;
    wait_cyc(19); chk("t3_ovf_c19", bus.overflow, 2'b00);
    wait_cyc(20); bus.pulse_in = 2'b00;
    chk("t3_ovf_c20", bus.overflow, 2'b01);
    wait_cyc(82); chk("t3_busy_c82", bus.busy, 2'b01);
    wait_cyc(83); chk("t3_busy_c83", bus.busy, 2'b00);
    wait_cyc(90); end_test("t3");

    // 4: strobe on the last gap cycle restarts directly
    start_test("last gap strobe");
    q0.push_back('{11, 4});
    q0.push_back('{19, 4});
    wait_cyc(10); bus.pulse_in = 2'b01;
    wait_cyc(11); bus.pulse_in = 2'b00;
    wait_cyc(18); bus.pulse_in = 2'b01;
    chk("t4_busy_c18", bus.busy, 2'b01);
    wait_cyc(19); bus.pulse_in = 2'b00;
    chk("t4_level_c19", bus.level_out, 2'b01);
    wait_cyc(27); chk("t4_busy_c27", bus.busy, 2'b00);
    wait_cyc(35); end_test("t4");

    // 5: overflow clear, then clear colliding with a new overflow
    start_test("overflow clear");
    for (int k = 0; k < 9; k++) q1.push_back('{11 + 8 * k, 4});
    wait_cyc(10); bus.pulse_in = 2'b10;
    wait_cyc(20); bus.pulse_in = 2'b00;
    chk("t5_ovf_c20", bus.overflow, 2'b10);
    wait_cyc(21); bus.clear_overflow = 1'b1;
    wait_cyc(22); bus.clear_overflow = 1'b0;
    chk("t5_ovf_c22", bus.overflow, 2'b00);
    wait_cyc(23); bus.clear_overflow = 1'b1; bus.pulse_in = 2'b10;
    wait_cyc(24); bus.clear_overflow = 1'b0; bus.pulse_in = 2'b00;
    chk("t5_ovf_c24", bus.overflow, 2'b10);
    wait_cyc(25); chk("t5_ovf_c25", bus.overflow, 2'b10);
    wait_cyc(83); chk("t5_busy_c83", bus.busy, 2'b00);
    wait_cyc(90); end_test("t5");

    // 6: asynchronous reset mid-pulse discards everything
    start_test("reset mid pulse");
    q0.push_back('{11, 1});
    q1.push_back('{11, 1});
    wait_cyc(10); bus.pulse_in = 2'b11;
    wait_cyc(11); chk("t6_level_c11", bus.level_out, 2'b11);
    wait_cyc(12); async_nreset = 1'b0;
    #1;
    chk("t6_rst_level", bus.level_out, 2'b00);
    chk("t6_rst_busy", bus.busy, 2'b00);
    chk("t6_rst_ovf", bus.overflow, 2'b00);
    bus.pulse_in = 2'b00;
    wait_cyc(15); async_nreset = 1'b1;
    wait_cyc(16); chk("t6_busy_c16", bus.busy, 2'b00);
    wait_cyc(40); chk("t6_busy_c40", bus.busy, 2'b00);
    end_test("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
